pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline control unit that drives the stall/bubble inputs of the F/D, D/E (decode_reg), E/M and M/W registers.
//  Detects load-use hazards and applies branch-mispredict flushes.
//  Sequences multi-cycle mul/div waits and memory waits with an FSM, including a mul/div watchdog and saturating perf counters.
// PARAMETERS
//  CNT_W       32  width of stall_cnt_o / flush_cnt_o
//  MD_TIMEOUT  64  max cycles in MD_WAIT before forced exit (>=2)
// PORTS
//  clk_i          in   1            clock, rising edge
//  rst_n          in   1            synchronous, active-low reset
//  D_rs1_i        in   5            rs1 index of instr in D
//  D_rs2_i        in   5            rs2 index of instr in D
//  D_use_rs1_i    in   1            D instr reads rs1
//  D_use_rs2_i    in   1            D instr reads rs2
//  DD_load_op_i   in   LOAD_WIDTH   load op of instr in E (0 = not a load)
//  DD_need_dstE_i in   1            instr in E writes a register
//  DD_dstE_i      in   5            destination of instr in E
//  E_mispredict_i in   1            1-cycle pulse: branch in E mispredicted
//  E_md_start_i   in   1            multi-cycle mul/div starts in E this cycle
//  E_md_done_i    in   1            mul/div result valid this cycle
//  M_mem_req_i    in   1            memory access pending in M
//  M_mem_ack_i    in   1            memory access completes this cycle
//  F_stall_o      out  1            hold PC
//  F_bubble_o     out  1            clear F/D register
//  D_stall_o      out  1            hold F/D register
//  D_bubble_o     out  1            clear D/E register (to decode_reg D_bubble_i)
//  E_stall_o      out  1            hold D/E register (to decode_reg D_stall_i)
//  M_bubble_o     out  1            clear E/M register
//  M_stall_o      out  1            hold E/M register
//  W_bubble_o     out  1            clear M/W register
//  state_o        out  2            FSM state
//  md_timeout_o   out  1            sticky watchdog flag
//  stall_cnt_o    out  CNT_W        cycles with F_stall_o=1, saturating
//  flush_cnt_o    out  CNT_W        applied flushes, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at clk_i edge):
//    - state=RUN; pend_flush=0; md_timeout_o=0; both counters=0; watchdog=0.
//    - While rst_n=0, all stall/bubble outputs = 0.
//  - Stall/bubble outputs are combinational from state + inputs. State, pend_flush, counters and watchdog are registered.
//  - States: RUN=0, MD_WAIT=1, MEM_WAIT=2.
//  - RUN, evaluated in priority order:
//    1. mem = M_mem_req_i & ~M_mem_ack_i.
//       - Outputs: F/D/E/M stall=1, W_bubble=1.
//       - Next state: MEM_WAIT. Mispredict this cycle sets pend_flush.
//    2. E_mispredict_i.
//       - Outputs: F_bubble=1, D_bubble=1.
//       - flush_cnt+1. Load-use is suppressed.
//    3. md = E_md_start_i & ~E_md_done_i.
//       - Outputs: F/D/E/M stall=1, W_bubble=0, M_bubble=1.
//       - Next state: MD_WAIT; watchdog=1.
//    4. Load-use: DD_load_op_i!=0 & DD_need_dstE_i & DD_dstE_i!=0 & ((D_use_rs1_i & D_rs1_i==DD_dstE_i) | (D_use_rs2_i & D_rs2_i==DD_dstE_i)).
//       - Outputs: F_stall=1, D_stall=1, D_bubble=1. Exactly 1 cycle; stays in RUN.
//  - MD_WAIT: F/D/E/M stall=1, M_bubble=1 (bubble wins at E/M).
//    - E_md_done_i: outputs return to normal in that cycle; next state RUN.
//    - Otherwise watchdog+1. When watchdog reaches MD_TIMEOUT: set md_timeout_o; next state RUN.
//    - E_mispredict_i during MD_WAIT sets pend_flush.
//  - MEM_WAIT: F/D/E/M stall=1, W_bubble=1.
//    - M_mem_ack_i: stalls drop that cycle; next state RUN.
//  - pend_flush: applied on the first RUN cycle after a wait state, as F_bubble=D_bubble=1.
//    - flush_cnt+1, then cleared. Overrides load-use in that cycle.
//  - Counters saturate at 2^CNT_W-1. Never more than one increment per cycle.
//  - rst_n=0 mid-wait: returns to RUN and drops pend_flush in that edge.
// STRUCTURE
//  - define.v: LOAD_WIDTH; new `HZ_RUN/`HZ_MD_WAIT/`HZ_MEM_WAIT state encodings.
//  - Sub-module sat_counter (width CNT_W, inc, rst_n), instantiated twice.
//  - The rest is a single flat module.
// TESTING
//  1. Load x5 in E, D reads rs1=x5 -> 1 cycle: F_stall=D_stall=D_bubble=1; next cycle all 0; stall_cnt=1.
//  2. Load x0 in E, D reads x0 -> no stall (x0 exempt).
//  3. E_mispredict_i coincident with load-use -> F_bubble=D_bubble=1, D_stall=0; flush_cnt=1.
//  4. E_md_start_i, done after 5 cycles -> state=1 for 5 cycles with E_stall=M_bubble=1; RUN after; stall_cnt=6.
//  5. MD_TIMEOUT=8, no done -> md_timeout_o=1 at cycle 8, state=0; flag held until rst_n=0.
//  6. M_mem_req_i held, ack at cycle 3, mispredict at cycle 1 -> stalls for cycles 0-2; cycle 4 F_bubble=D_bubble=1; flush_cnt=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared widths and FSM state encoding for the pipeline hazard unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

  localparam int LOAD_WIDTH = 3;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MD_WAIT  = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ============================================================================
// Module   : pipe_hazard_ctrl_sat_counter
// Brief    : Up-counter that sticks at its all-ones value.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline stall/bubble control: load-use, mispredict flush, mul/div
//            and memory wait sequencing with watchdog and perf counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [4:0]            D_rs1_i,
  input  logic [4:0]            D_rs2_i,
  input  logic                  D_use_rs1_i,
  input  logic                  D_use_rs2_i,
  input  logic [LOAD_WIDTH-1:0] DD_load_op_i,
  input  logic                  DD_need_dstE_i,
  input  logic [4:0]            DD_dstE_i,
  input  logic                  E_mispredict_i,
  input  logic                  E_md_start_i,
  input  logic                  E_md_done_i,
  input  logic                  M_mem_req_i,
  input  logic                  M_mem_ack_i,
  output logic                  F_stall_o,
  output logic                  F_bubble_o,
  output logic                  D_stall_o,
  output logic                  D_bubble_o,
  output logic                  E_stall_o,
  output logic                  M_bubble_o,
  output logic                  M_stall_o,
  output logic                  W_bubble_o,
  output logic [1:0]            state_o,
  output logic                  md_timeout_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam int WD_W = $clog2(MD_TIMEOUT + 1);

  hz_state_e       state_q;
  logic            pend_flush_q;
  logic [WD_W-1:0] wd_q;
  logic            md_timeout_q;

  logic mem_wait;
  logic md_wait;
  logic flush;
  logic load_use;
  logic flush_inc;

  assign mem_wait = M_mem_req_i & ~M_mem_ack_i;
  assign md_wait  = E_md_start_i & ~E_md_done_i;
  assign flush    = E_mispredict_i | pend_flush_q;
  assign load_use = (DD_load_op_i != '0) && DD_need_dstE_i && (DD_dstE_i != 5'd0) &&
                    ((D_use_rs1_i && (D_rs1_i == DD_dstE_i)) ||
                     (D_use_rs2_i && (D_rs2_i == DD_dstE_i)));

  always_comb begin
    F_stall_o  = 1'b0;
    F_bubble_o = 1'b0;
    D_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_stall_o  = 1'b0;
    M_bubble_o = 1'b0;
    M_stall_o  = 1'b0;
    W_bubble_o = 1'b0;
    flush_inc  = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        HZ_RUN: begin
          if (mem_wait) begin
            {F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_bubble_o} = '1;
          end else if (flush) begin
            F_bubble_o = 1'b1;
            D_bubble_o = 1'b1;
            flush_inc  = 1'b1;
          end else if (md_wait) begin
            {F_stall_o, D_stall_o, E_stall_o, M_stall_o, M_bubble_o} = '1;
          end else if (load_use) begin
            {F_stall_o, D_stall_o, D_bubble_o} = '1;
          end
        end
        HZ_MD_WAIT: begin
          if (!E_md_done_i) begin
            {F_stall_o, D_stall_o, E_stall_o, M_stall_o, M_bubble_o} = '1;
          end
        end
        HZ_MEM_WAIT: begin
          if (!M_mem_ack_i) begin
            {F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_bubble_o} = '1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q      <= HZ_RUN;
      pend_flush_q <= 1'b0;
      wd_q         <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        HZ_RUN: begin
          // A mispredict hidden behind a memory stall is replayed once the wait ends.
          if (mem_wait) begin
            state_q <= HZ_MEM_WAIT;
            if (E_mispredict_i) pend_flush_q <= 1'b1;
          end else if (flush) begin
            pend_flush_q <= 1'b0;
          end else if (md_wait) begin
            state_q <= HZ_MD_WAIT;
            wd_q    <= WD_W'(1);
          end
        end
        HZ_MD_WAIT: begin
          if (E_mispredict_i) pend_flush_q <= 1'b1;
          if (E_md_done_i) begin
            state_q <= HZ_RUN;
          end else begin
            wd_q <= wd_q + WD_W'(1);
            if (wd_q == WD_W'(MD_TIMEOUT - 1)) begin
              md_timeout_q <= 1'b1;
              state_q      <= HZ_RUN;
            end
          end
        end
        HZ_MEM_WAIT: begin
          if (E_mispredict_i) pend_flush_q <= 1'b1;
          if (M_mem_ack_i) state_q <= HZ_RUN;
        end
        default: state_q <= HZ_RUN;
      endcase
    end
  end

  assign state_o      = state_q;
  assign md_timeout_o = md_timeout_q;

  pipe_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (F_stall_o),
    .cnt_o (stall_cnt_o)
  );

  pipe_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int MD_TIMEOUT = 8;

  // {F_stall, F_bubble, D_stall, D_bubble, E_stall, M_bubble, M_stall, W_bubble}
  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1011_0000;
  localparam logic [7:0] O_FLUSH = 8'b0101_0000;
  localparam logic [7:0] O_MD    = 8'b1010_1110;
  localparam logic [7:0] O_MEM   = 8'b1010_1011;

  logic clk_i = 1'b0;
  logic rst_n;
  logic [4:0] D_rs1_i, D_rs2_i, DD_dstE_i;
  logic D_use_rs1_i, D_use_rs2_i, DD_need_dstE_i;
  logic [2:0] DD_load_op_i;
  logic E_mispredict_i, E_md_start_i, E_md_done_i, M_mem_req_i, M_mem_ack_i;
  logic F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_stall_o, M_bubble_o, M_stall_o, W_bubble_o;
  logic [1:0] state_o;
  logic md_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [7:0] outs;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .D_rs1_i(D_rs1_i), .D_rs2_i(D_rs2_i), .D_use_rs1_i(D_use_rs1_i), .D_use_rs2_i(D_use_rs2_i),
    .DD_load_op_i(DD_load_op_i), .DD_need_dstE_i(DD_need_dstE_i), .DD_dstE_i(DD_dstE_i),
    .E_mispredict_i(E_mispredict_i), .E_md_start_i(E_md_start_i), .E_md_done_i(E_md_done_i),
    .M_mem_req_i(M_mem_req_i), .M_mem_ack_i(M_mem_ack_i),
    .F_stall_o(F_stall_o), .F_bubble_o(F_bubble_o), .D_stall_o(D_stall_o), .D_bubble_o(D_bubble_o),
    .E_stall_o(E_stall_o), .M_bubble_o(M_bubble_o), .M_stall_o(M_stall_o), .W_bubble_o(W_bubble_o),
    .state_o(state_o), .md_timeout_o(md_timeout_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  assign outs = {F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_stall_o, M_bubble_o, M_stall_o, W_bubble_o};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    D_rs1_i = 5'd0; D_rs2_i = 5'd0; D_use_rs1_i = 1'b0; D_use_rs2_i = 1'b0;
    DD_load_op_i = 3'd0; DD_need_dstE_i = 1'b0; DD_dstE_i = 5'd0;
    E_mispredict_i = 1'b0; E_md_start_i = 1'b0; E_md_done_i = 1'b0;
    M_mem_req_i = 1'b0; M_mem_ack_i = 1'b0;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_load(input logic [4:0] dst, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    DD_load_op_i = 3'd2; DD_need_dstE_i = 1'b1; DD_dstE_i = dst;
    D_rs1_i = rs1; D_use_rs1_i = u1; D_rs2_i = rs2; D_use_rs2_i = u2;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    M_mem_req_i = 1'b1;
    tick(); settle();
    check_eq("rst_outs_gated", {24'd0, outs}, {24'd0, O_NONE});
    clear_inputs();
    tick();
    rst_n = 1'b1; settle();
    check_eq("rst_state", {30'd0, state_o}, 32'd0);
    check_eq("rst_timeout", {31'd0, md_timeout_o}, 32'd0);
    check_eq("rst_stall_cnt", {28'd0, stall_cnt_o}, 32'd0);
    check_eq("rst_flush_cnt", {28'd0, flush_cnt_o}, 32'd0);
    check_eq("rst_outs_idle", {24'd0, outs}, {24'd0, O_NONE});

    // Load-use on rs1, then on rs2, plus cases that must not stall.
    set_load(5'd5, 5'd5, 1'b1, 5'd9, 1'b1); settle();
    check_eq("lu_rs1", {24'd0, outs}, {24'd0, O_LU});
    tick(); clear_inputs(); settle();
    check_eq("lu_release", {24'd0, outs}, {24'd0, O_NONE});
    check_eq("lu_state", {30'd0, state_o}, 32'd0);
    check_eq("lu_stall_cnt", {28'd0, stall_cnt_o}, 32'd1);
    set_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b1); settle();
    check_eq("lu_rs2", {24'd0, outs}, {24'd0, O_LU});
    tick(); set_load(5'd7, 5'd7, 1'b0, 5'd7, 1'b0); settle();
    check_eq("lu_unused_regs", {24'd0, outs}, {24'd0, O_NONE});
    set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); settle();
    check_eq("lu_x0_exempt", {24'd0, outs}, {24'd0, O_NONE});
    set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0); DD_need_dstE_i = 1'b0; settle();
    check_eq("lu_no_dst", {24'd0, outs}, {24'd0, O_NONE});
    set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0); DD_load_op_i = 3'd0; settle();
    check_eq("lu_not_load", {24'd0, outs}, {24'd0, O_NONE});
    tick(); clear_inputs(); settle();
    check_eq("lu_stall_cnt2", {28'd0, stall_cnt_o}, 32'd2);

    // Mispredict beats load-use.
    do_reset();
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); E_mispredict_i = 1'b1; settle();
    check_eq("mp_over_lu", {24'd0, outs}, {24'd0, O_FLUSH});
    tick(); clear_inputs(); settle();
    check_eq("mp_flush_cnt", {28'd0, flush_cnt_o}, 32'd1);
    check_eq("mp_stall_cnt", {28'd0, stall_cnt_o}, 32'd0);

    // Mul/div: start at cycle 0, done at cycle 6.
    do_reset();
    E_md_start_i = 1'b1; settle();
    check_eq("md_c0_outs", {24'd0, outs}, {24'd0, O_MD});
    for (int c = 1; c <= 5; c++) begin
      tick(); E_md_start_i = 1'b0; settle();
      check_eq($sformatf("md_c%0d_state", c), {30'd0, state_o}, 32'd1);
      check_eq($sformatf("md_c%0d_outs", c), {24'd0, outs}, {24'd0, O_MD});
    end
    tick(); E_md_done_i = 1'b1; settle();
    check_eq("md_done_outs", {24'd0, outs}, {24'd0, O_NONE});
    tick(); clear_inputs(); settle();
    check_eq("md_end_state", {30'd0, state_o}, 32'd0);
    check_eq("md_stall_cnt", {28'd0, stall_cnt_o}, 32'd6);
    check_eq("md_no_timeout", {31'd0, md_timeout_o}, 32'd0);

    // Watchdog: no done, MD_TIMEOUT = 8.
    do_reset();
    E_md_start_i = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick(); E_md_start_i = 1'b0; settle();
      check_eq($sformatf("wd_c%0d_state", c), {30'd0, state_o}, 32'd1);
      check_eq($sformatf("wd_c%0d_flag", c), {31'd0, md_timeout_o}, 32'd0);
    end
    tick(); settle();
    check_eq("wd_c8_state", {30'd0, state_o}, 32'd0);
    check_eq("wd_c8_flag", {31'd0, md_timeout_o}, 32'd1);
    check_eq("wd_c8_outs", {24'd0, outs}, {24'd0, O_NONE});
    check_eq("wd_stall_cnt", {28'd0, stall_cnt_o}, 32'd8);
    tick(); tick(); settle();
    check_eq("wd_flag_sticky", {31'd0, md_timeout_o}, 32'd1);
    do_reset(); settle();
    check_eq("wd_flag_cleared", {31'd0, md_timeout_o}, 32'd0);

    // Memory wait with a mispredict hidden behind it; ack at cycle 3.
    do_reset();
    M_mem_req_i = 1'b1; settle();
    check_eq("mem_c0_outs", {24'd0, outs}, {24'd0, O_MEM});
    tick(); E_mispredict_i = 1'b1; settle();
    check_eq("mem_c1_state", {30'd0, state_o}, 32'd2);
    check_eq("mem_c1_outs", {24'd0, outs}, {24'd0, O_MEM});
    tick(); E_mispredict_i = 1'b0; settle();
    check_eq("mem_c2_outs", {24'd0, outs}, {24'd0, O_MEM});
    tick(); M_mem_ack_i = 1'b1; settle();
    check_eq("mem_c3_outs", {24'd0, outs}, {24'd0, O_NONE});
    check_eq("mem_c3_state", {30'd0, state_o}, 32'd2);
    tick(); clear_inputs(); set_load(5'd6, 5'd6, 1'b1, 5'd0, 1'b0); settle();
    check_eq("mem_c4_pend_flush", {24'd0, outs}, {24'd0, O_FLUSH});
    check_eq("mem_c4_state", {30'd0, state_o}, 32'd0);
    tick(); clear_inputs(); settle();
    check_eq("mem_c5_outs", {24'd0, outs}, {24'd0, O_NONE});
    check_eq("mem_flush_cnt", {28'd0, flush_cnt_o}, 32'd1);
    check_eq("mem_stall_cnt", {28'd0, stall_cnt_o}, 32'd3);

    // Stall counter saturation, then reset in the middle of a wait.
    do_reset();
    M_mem_req_i = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    settle();
    check_eq("sat_stall_cnt", {28'd0, stall_cnt_o}, 32'd15);
    E_mispredict_i = 1'b1;
    tick(); E_mispredict_i = 1'b0; rst_n = 1'b0; settle();
    check_eq("rst_mid_outs", {24'd0, outs}, {24'd0, O_NONE});
    tick(); rst_n = 1'b1; M_mem_req_i = 1'b0; settle();
    check_eq("rst_mid_state", {30'd0, state_o}, 32'd0);
    check_eq("rst_mid_no_flush", {24'd0, outs}, {24'd0, O_NONE});
    tick(); settle();
    check_eq("rst_mid_flush_cnt", {28'd0, flush_cnt_o}, 32'd0);
    check_eq("rst_mid_stall_cnt", {28'd0, stall_cnt_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
